// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the 7-segment scan driver.
// Segment vectors are [0:6] so that index 0 is segment a and index 6 is segment g.
package seg7_pkg;

  typedef logic [0:6] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Literals are written a..g from left to right.
  localparam seg7_t GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // A raw field has bit0 = a, so its bit order is the reverse of seg7_t.
  function automatic seg7_t raw_to_seg7(input logic [6:0] field);
    seg7_t seg;
    for (int k = 0; k < 7; k++) begin
      seg[k] = field[k];
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle of the scan driver: data, control, and the anode/segment pins.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BRIGHT_W   = 4
);
  import seg7_pkg::*;

  logic                    en;
  logic                    hex_mode;
  logic [NUM_DIGITS*7-1:0] digits;
  logic                    load;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   anode_o;
  seg7_t                   seg_o;
  logic                    frame_o;

  modport master (
    output en, hex_mode, digits, load, brightness,
    input  anode_o, seg_o, frame_o
  );

  modport slave (
    input  en, hex_mode, digits, load, brightness,
    output anode_o, seg_o, frame_o
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to segment pattern, active-high.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output seg7_t      seg
);

  assign seg = GLYPH[value];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner with frame-synchronous double buffering,
// PWM brightness, an inter-digit blanking gap, and raw/hex decoding.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned CLK_DIV          = 1000,
  parameter int unsigned BRIGHT_W         = 4,
  parameter int unsigned BLANK_TICKS      = 1,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned SLOT = 1 << BRIGHT_W;
  localparam int unsigned PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW   = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam seg7_t SEG_OFF = {7{SEG_ACTIVE_LOW}};

  logic [PW-1:0]           p_q;
  logic [BRIGHT_W-1:0]     s_q;
  logic [DW-1:0]           d_q;
  logic [NUM_DIGITS*7-1:0] pend_digits_q, act_digits_q;
  logic                    pend_hex_q, act_hex_q, pend_flag_q;
  logic [NUM_DIGITS-1:0]   anode_q;
  seg7_t                   seg_q;
  logic                    frame_q;

  logic                    tick, slot_end, frame_end, lit;
  logic [BRIGHT_W:0]       lit_end;
  logic [6:0]              field;
  seg7_t                   hex_seg, seg_lit, seg_pol;
  logic [NUM_DIGITS-1:0]   onehot, anode_pol;

  assign tick      = bus.en && (p_q == PW'(CLK_DIV - 1));
  assign slot_end  = (s_q == BRIGHT_W'(SLOT - 1));
  assign frame_end = tick && slot_end && (d_q == DW'(NUM_DIGITS - 1));

  // One extra bit so BLANK_TICKS + brightness saturates past the slot instead of wrapping.
  assign lit_end = {1'b0, bus.brightness} + (BRIGHT_W + 1)'(BLANK_TICKS);
  assign lit     = bus.en && (s_q >= BRIGHT_W'(BLANK_TICKS)) && ({1'b0, s_q} < lit_end);

  always_comb begin
    field = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d_q == DW'(i)) field = act_digits_q[7*i +: 7];
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .value (field[3:0]),
    .seg   (hex_seg)
  );

  always_comb begin
    seg_lit   = act_hex_q ? hex_seg : raw_to_seg7(field);
    seg_pol   = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    onehot    = NUM_DIGITS'(1) << d_q;
    anode_pol = ANODE_ACTIVE_LOW ? ~onehot : onehot;
  end

  // Scan position: prescaler, tick within slot, digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      s_q <= '0;
      d_q <= '0;
    end else if (!bus.en) begin
      p_q <= '0;
      s_q <= '0;
      d_q <= '0;
    end else if (tick) begin
      p_q <= '0;
      s_q <= s_q + BRIGHT_W'(1);
      if (slot_end) d_q <= (d_q == DW'(NUM_DIGITS - 1)) ? '0 : d_q + DW'(1);
    end else begin
      p_q <= p_q + PW'(1);
    end
  end

  // Double buffer: the active copy only changes at a frame boundary, or at once while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits_q <= '0;
      pend_hex_q    <= 1'b0;
      pend_flag_q   <= 1'b0;
      act_digits_q  <= '0;
      act_hex_q     <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_digits_q <= bus.digits;
        pend_hex_q    <= bus.hex_mode;
      end
      if (!bus.en || frame_end) begin
        if (bus.load) begin
          act_digits_q <= bus.digits;
          act_hex_q    <= bus.hex_mode;
          pend_flag_q  <= 1'b0;
        end else if (frame_end && pend_flag_q) begin
          act_digits_q <= pend_digits_q;
          act_hex_q    <= pend_hex_q;
          pend_flag_q  <= 1'b0;
        end
      end else if (bus.load) begin
        pend_flag_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      anode_q <= lit ? anode_pol : ANODE_OFF;
      seg_q   <= lit ? seg_pol : SEG_OFF;
      frame_q <= frame_end;
    end
  end

  assign bus.anode_o = anode_q;
  assign bus.seg_o   = seg_q;
  assign bus.frame_o = frame_q;

endmodule
